md5_pad_loader: RTL

- Front end (initiator) of the MD5 core's load interface.
- Collects a password byte stream and builds the single padded 512-bit MD5 block, with little-endian word packing, a 0x80 pad byte and a 64-bit bit length.
- Drives the core with newtext plus four 128-bit load beats, waits for the core's ready pulse, then compares the digest against an expected digest for authentication.

---
 rtl/md5_pad_loader.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/md5_pad_loader.sv
// Load-side initiator for the MD5 core: packs a password into one padded block,
// streams it as newtext plus four 128-bit beats, then checks the returned digest.
module md5_pad_loader #(
  parameter int MAX_BYTES = 55,
  parameter int TIMEOUT   = 255
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         byte_valid_i,
  input  logic [7:0]   byte_data_i,
  input  logic         byte_last_i,
  output logic         byte_ready_o,
  input  logic [127:0] expected_i,
  output logic         md5_newtext_o,
  output logic         md5_load_o,
  output logic [127:0] md5_data_o,
  input  logic         md5_ready_i,
  input  logic [127:0] md5_digest_i,
  output logic         busy_o,
  output logic         done_o,
  output logic         match_o,
  output logic         error_o,
  output logic [127:0] digest_o
);

  typedef enum logic [2:0] {
    S_COLLECT, S_PAD, S_NEWTEXT, S_LOAD, S_WAIT, S_DONE, S_ERR
  } state_t;

  localparam int              TW     = $clog2(TIMEOUT + 1);
  localparam logic [5:0]      MAX_C  = 6'(MAX_BYTES);
  localparam logic [TW-1:0]   T_LAST = TW'(TIMEOUT - 1);

  state_t         state, state_nx;
  logic [511:0]   blk;
  logic [5:0]     cnt;
  logic           ovf;
  logic [TW-1:0]  tcnt;
  logic [1:0]     beat;
  logic [127:0]   digest_q;
  logic           match_q;
  logic           acc;
  logic           cmp;
  logic [8:0]     wr_pos;

  assign acc = byte_valid_i && (state == S_COLLECT);
  assign cmp = (digest_q == expected_i);

  // Byte i lands in word i/4 (word 0 at the top of the block), little-endian within the word
  assign wr_pos = 9'd480 - {cnt[5:2], 5'b0} + 9'({cnt[1:0], 3'b0});

  always_ff @(posedge clk) begin
    if (reset) state <= S_COLLECT;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_COLLECT: if (acc && byte_last_i)
                   state_nx = (ovf || cnt == MAX_C) ? S_ERR : S_PAD;
      S_PAD:     state_nx = S_NEWTEXT;
      S_NEWTEXT: state_nx = S_LOAD;
      S_LOAD:    if (beat == 2'd3) state_nx = S_WAIT;
      // A ready pulse on the final timeout cycle still counts as success
      S_WAIT:    if (md5_ready_i)          state_nx = S_DONE;
                 else if (tcnt == T_LAST)  state_nx = S_ERR;
      S_DONE:    state_nx = S_COLLECT;
      S_ERR:     state_nx = S_COLLECT;
      default:   state_nx = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blk      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      tcnt     <= '0;
      beat     <= '0;
      digest_q <= '0;
      match_q  <= 1'b0;
    end else begin
      case (state)
        S_COLLECT: if (acc) begin
          if (cnt < MAX_C) begin
            blk[wr_pos +: 8] <= byte_data_i;
            cnt              <= cnt + 6'd1;
          end else begin
            ovf <= 1'b1;
          end
        end
        S_PAD: begin
          blk[wr_pos +: 8] <= 8'h80;
          blk[63:32]       <= {23'd0, cnt, 3'd0};
        end
        S_LOAD: beat <= beat + 2'd1;
        S_WAIT: begin
          tcnt <= tcnt + 1'b1;
          if (md5_ready_i) digest_q <= md5_digest_i;
        end
        S_DONE: begin
          match_q <= cmp;
          blk     <= '0;
          cnt     <= '0;
          ovf     <= 1'b0;
          tcnt    <= '0;
        end
        S_ERR: begin
          match_q <= 1'b0;
          blk     <= '0;
          cnt     <= '0;
          ovf     <= 1'b0;
          tcnt    <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    md5_data_o = '0;
    if (state == S_LOAD) begin
      case (beat)
        2'd0: md5_data_o = blk[511:384];
        2'd1: md5_data_o = blk[383:256];
        2'd2: md5_data_o = blk[255:128];
        default: md5_data_o = blk[127:0];
      endcase
    end
  end

  assign byte_ready_o  = (state == S_COLLECT);
  assign busy_o        = (state != S_COLLECT);
  assign md5_newtext_o = (state == S_NEWTEXT);
  assign md5_load_o    = (state == S_LOAD);
  assign done_o        = (state == S_DONE);
  assign error_o       = (state == S_ERR);
  assign match_o       = (state == S_DONE) ? cmp : (state == S_ERR) ? 1'b0 : match_q;
  assign digest_o      = digest_q;

endmodule
